// File: rtl/spi_pkg.sv
// Shared SPI link definitions.
// Word format common to the transmitter and receiver.
package spi_pkg;

  localparam int SPI_DW = 8;
  localparam logic DC_CMD = 1'b0;
  localparam logic DC_DATA = 1'b1;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } spi_word_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// First-word-fall-through FIFO for received words.
// Head word reads as zero while empty.
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int W     = SPI_DW + 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  // Storage array; contents are masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally; count tells full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_rx_slave.sv
// Oversampling mode-0 SPI receiver.
// Tags bytes with dc and queues them for a consumer.
module spi_rx_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DW,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              scl,
  input  logic              sda,
  input  logic              dc,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_dc,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_active,
  output logic              frame_done,
  output logic [7:0]        byte_count,
  output logic              err_partial,
  output logic              err_overflow,
  input  logic              clr_err
);

  localparam int SS = SYNC_STAGES;
  localparam int BW = $clog2(DATA_W) + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [SS-1:0]     cs_q, scl_q, sda_q, dc_q;
  logic              cs_d, scl_d;
  logic [SS:0]       fill;
  logic              armed;
  logic              cs_s, scl_s, sda_s, dc_s;
  logic              cs_fall, cs_rise, scl_rise;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-2:0] shift;
  logic              last_bit;
  logic              push, pop, full, empty;
  logic [DATA_W:0]   wword, rword;
  logic [CW-1:0]     fifo_count;
  logic              partial_evt, ovf_evt;
  logic              count_unused;

  assign cs_s  = cs_q[SS-1];
  assign scl_s = scl_q[SS-1];
  assign sda_s = sda_q[SS-1];
  assign dc_s  = dc_q[SS-1];

  // A falling cs only counts once a genuine idle-high cs has
  // been seen after reset, so an interrupted frame is not resumed.
  assign cs_fall  = armed & cs_d & ~cs_s;
  assign cs_rise  = ~cs_d & cs_s & frame_active;
  assign scl_rise = ~scl_d & scl_s & ~cs_s & frame_active;
  assign last_bit = (bit_cnt == BW'(DATA_W - 1));

  assign push  = scl_rise & last_bit;
  assign wword = {dc_s, shift, sda_s};
  assign pop   = rx_valid & rx_ready;

  assign partial_evt = cs_rise & (bit_cnt != '0);
  assign ovf_evt     = push & full & ~pop;

  assign rx_valid = ~empty;
  assign rx_dc    = rword[DATA_W];
  assign rx_data  = rword[DATA_W-1:0];
  assign count_unused = ^fifo_count;

  // Input synchronisers, edge-detect copies and post-reset arming.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q  <= '1;
      scl_q <= '0;
      sda_q <= '0;
      dc_q  <= '0;
      cs_d  <= 1'b1;
      scl_d <= 1'b0;
      fill  <= '0;
      armed <= 1'b0;
    end else begin
      cs_q  <= {cs_q[SS-2:0], cs};
      scl_q <= {scl_q[SS-2:0], scl};
      sda_q <= {sda_q[SS-2:0], sda};
      dc_q  <= {dc_q[SS-2:0], dc};
      cs_d  <= cs_s;
      scl_d <= scl_s;
      fill  <= {fill[SS-1:0], 1'b1};
      armed <= armed | (fill[SS] & cs_s);
    end
  end

  // Framing, deserialising, byte counting and sticky errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      bit_cnt      <= '0;
      shift        <= '0;
      byte_count   <= '0;
      err_partial  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (cs_fall) begin
        frame_active <= 1'b1;
        bit_cnt      <= '0;
        byte_count   <= '0;
      end else if (cs_rise) begin
        frame_active <= 1'b0;
        frame_done   <= 1'b1;
        bit_cnt      <= '0;
      end else if (scl_rise) begin
        shift <= {shift[DATA_W-3:0], sda_s};
        if (last_bit) begin
          bit_cnt <= '0;
          if (byte_count != 8'hFF)
            byte_count <= byte_count + 8'd1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      err_partial  <= (err_partial & ~clr_err) | partial_evt;
      err_overflow <= (err_overflow & ~clr_err) | ovf_evt;
    end
  end

  spi_rx_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wword),
    .pop   (pop),
    .rdata (rword),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

endmodule
